// File: rtl/board_editor_pkg.sv
// rtl/board_editor_pkg.sv - shared board geometry, position/word types and editor FSM states
package board_editor_pkg;

  localparam int BOARD_SIZE     = 256;
  localparam int LOG_BOARD_SIZE = 8;
  localparam int WORD_SIZE      = 16;
  localparam int LOG_WORD_SIZE  = 4;
  localparam int LOG_MAX_ADDR   = 12;
  localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;
  localparam int MAX_ADDR       = BOARD_SIZE * BOARD_SIZE / WORD_SIZE;

  typedef logic [LOG_BOARD_SIZE-1:0] coord_t;
  typedef logic [LOG_MAX_ADDR-1:0]   addr_t;
  typedef logic [WORD_SIZE-1:0]      word_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_W1,
    RD_W2,
    WRITE,
    CLEAR
  } editor_state_t;

endpackage

// File: rtl/board_editor_if.sv
// rtl/board_editor_if.sv - board BRAM port B (read + write) bundle
interface board_editor_if;

  board_editor_pkg::addr_t addr_r_out;
  board_editor_pkg::word_t data_r_in;
  board_editor_pkg::addr_t addr_w_out;
  board_editor_pkg::word_t data_w_out;
  logic                    we_out;

  modport master (
    output addr_r_out,
    output addr_w_out,
    output data_w_out,
    output we_out,
    input  data_r_in
  );

  modport slave (
    input  addr_r_out,
    input  addr_w_out,
    input  data_w_out,
    input  we_out,
    output data_r_in
  );

endinterface

// File: rtl/board_editor_cell_addr_calc.sv
// rtl/board_editor_cell_addr_calc.sv - board (x,y) to memory word address and one-hot cell mask
module board_editor_cell_addr_calc
  import board_editor_pkg::*;
(
  input  pos_t  pos_i,
  output addr_t addr_o,
  output word_t mask_o
);

  logic [LOG_WORD_SIZE-1:0] bit_idx;

  // y*WORDS_PER_ROW + (x >> LOG_WORD_SIZE); both factors are powers of two so this is a concatenation
  assign addr_o = {pos_i.y, pos_i.x[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]};

  // WORD_SIZE-1-x[3:0]: leftmost cell sits in the MSB
  assign bit_idx = ~pos_i.x[LOG_WORD_SIZE-1:0];
  assign mask_o  = word_t'(1) << bit_idx;

endmodule

// File: rtl/board_editor.sv
// rtl/board_editor.sv - applies cell toggles and full-board clears to BRAM port B during blanking
module board_editor
  import board_editor_pkg::*;
(
  input  logic           clk_130mhz,
  input  logic           rst_in,
  input  logic           blank_in,
  input  logic           toggle_in,
  input  logic           clear_in,
  input  coord_t         cursor_x_in,
  input  coord_t         cursor_y_in,
  board_editor_if.master bram,
  output logic           busy_out
);

  localparam logic [LOG_MAX_ADDR:0] LAST_WORD = (LOG_MAX_ADDR+1)'(MAX_ADDR - 1);

  editor_state_t         state_q, state_d;
  logic                  toggle_pend_q, toggle_pend_d;
  logic                  clear_pend_q, clear_pend_d;
  pos_t                  tpos_q, tpos_d;
  logic [LOG_MAX_ADDR:0] cnt_q, cnt_d;
  addr_t                 raddr_q, raddr_d;
  word_t                 mask_q, mask_d;
  word_t                 word_q, word_d;
  logic                  busy_q, busy_d;

  addr_t                 calc_addr;
  word_t                 calc_mask;
  logic                  we_w;
  addr_t                 waddr_w;
  word_t                 wdata_w;
  logic                  abort_w;

  board_editor_cell_addr_calc u_calc (
    .pos_i  (tpos_q),
    .addr_o (calc_addr),
    .mask_o (calc_mask)
  );

  // Leaving blanking, or a clear superseding the toggle, drops an in-flight read-modify-write
  assign abort_w = !blank_in || clear_pend_q;

  always_comb begin
    state_d       = state_q;
    toggle_pend_d = toggle_pend_q;
    clear_pend_d  = clear_pend_q;
    tpos_d        = tpos_q;
    cnt_d         = cnt_q;
    raddr_d       = raddr_q;
    mask_d        = mask_q;
    word_d        = word_q;
    we_w          = 1'b0;
    waddr_w       = '0;
    wdata_w       = '0;

    case (state_q)
      IDLE: begin
        if (blank_in && clear_pend_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (blank_in && toggle_pend_q) begin
          state_d = RD_ADDR;
          raddr_d = calc_addr;
          mask_d  = calc_mask;
        end
      end
      RD_ADDR: state_d = abort_w ? IDLE : RD_W1;
      RD_W1:   state_d = abort_w ? IDLE : RD_W2;
      RD_W2: begin
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          word_d  = bram.data_r_in;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (!abort_w) begin
          we_w          = 1'b1;
          waddr_w       = raddr_q;
          wdata_w       = word_q ^ mask_q;
          toggle_pend_d = 1'b0;
        end
      end
      CLEAR: begin
        if (blank_in) begin
          we_w    = 1'b1;
          waddr_w = cnt_q[LOG_MAX_ADDR-1:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            clear_pend_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // New requests are applied after the FSM so they win over same-cycle completion
    if (toggle_in && !clear_in) begin
      toggle_pend_d = 1'b1;
      tpos_d.x      = cursor_x_in;
      tpos_d.y      = cursor_y_in;
    end
    if (clear_in) begin
      clear_pend_d = 1'b1;
    end
    if (clear_pend_d) begin
      toggle_pend_d = 1'b0;
    end

    busy_d = toggle_pend_d || clear_pend_d || (state_d != IDLE);
  end

  always_ff @(posedge clk_130mhz or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      toggle_pend_q <= 1'b0;
      clear_pend_q  <= 1'b0;
      tpos_q        <= '0;
      cnt_q         <= '0;
      raddr_q       <= '0;
      mask_q        <= '0;
      word_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      toggle_pend_q <= toggle_pend_d;
      clear_pend_q  <= clear_pend_d;
      tpos_q        <= tpos_d;
      cnt_q         <= cnt_d;
      raddr_q       <= raddr_d;
      mask_q        <= mask_d;
      word_q        <= word_d;
      busy_q        <= busy_d;
    end
  end

  assign bram.addr_r_out = raddr_q;
  assign bram.we_out     = we_w;
  assign bram.addr_w_out = waddr_w;
  assign bram.data_w_out = wdata_w;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_board_editor.sv
// tb/tb_board_editor.sv - directed self-checking bench for board_editor with a 2-cycle BRAM model
module tb_board_editor;
  import board_editor_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   blank = 1'b0;
  logic   toggle = 1'b0;
  logic   clear = 1'b0;
  coord_t cx = '0;
  coord_t cy = '0;
  logic   busy;

  board_editor_if bram();

  board_editor dut (
    .clk_130mhz  (clk),
    .rst_in      (rst),
    .blank_in    (blank),
    .toggle_in   (toggle),
    .clear_in    (clear),
    .cursor_x_in (cx),
    .cursor_y_in (cy),
    .bram        (bram.master),
    .busy_out    (busy)
  );

  always #5 clk = ~clk;

  word_t mem [0:MAX_ADDR-1];
  word_t rd1;
  int    n_checks = 0;
  int    n_fail = 0;
  int    wr_total = 0;
  int    wr_nonzero = 0;

  // Port B model: read data two cycles after address, write on we
  always @(posedge clk) begin
    rd1            <= mem[bram.addr_r_out];
    bram.data_r_in <= rd1;
    if (bram.we_out) begin
      mem[bram.addr_w_out] <= bram.data_w_out;
      wr_total = wr_total + 1;
      if (bram.data_w_out != '0) wr_nonzero = wr_nonzero + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_run(input string tag, input coord_t x, input coord_t y,
                            input addr_t ea, input word_t ed);
    cx = x; cy = y; toggle = 1'b1;
    tick();
    toggle = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, " addr_r"}, 32'(bram.addr_r_out), 32'(ea));
    tick();
    tick();
    check({tag, " we early"}, 32'(bram.we_out), 32'd0);
    tick();
    check({tag, " we"}, 32'(bram.we_out), 32'd1);
    check({tag, " addr_w"}, 32'(bram.addr_w_out), 32'(ea));
    check({tag, " data_w"}, 32'(bram.data_w_out), 32'(ed));
    tick();
    check({tag, " we after"}, 32'(bram.we_out), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " mem"}, 32'(mem[ea]), 32'(ed));
  endtask

  initial begin
    int w0;
    int nz0;
    int exp_addr;
    int order_err;
    int blank_err;
    int data_err;
    int done_at;

    for (int i = 0; i < MAX_ADDR; i++) mem[i] = '0;

    #2 rst = 1'b1;
    tick();
    tick();
    check("rst we", 32'(bram.we_out), 32'd0);
    check("rst addr_r", 32'(bram.addr_r_out), 32'd0);
    check("rst addr_w", 32'(bram.addr_w_out), 32'd0);
    check("rst data_w", 32'(bram.data_w_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // 1, 2: toggle (17,3) sets then clears bit 14 of word 0x031
    blank = 1'b1;
    toggle_run("t1", 8'd17, 8'd3, 12'h031, 16'h4000);
    toggle_run("t2", 8'd17, 8'd3, 12'h031, 16'h0000);

    // 3: toggle during active video, cursor latched at request time
    mem[12'hFFC] = 16'h1234;
    blank = 1'b0;
    cx = 8'd200; cy = 8'd255; toggle = 1'b1;
    tick();
    toggle = 1'b0; cx = 8'd5; cy = 8'd0;
    w0 = wr_total;
    repeat (10) tick();
    check("t3 busy", 32'(busy), 32'd1);
    check("t3 no write", 32'(wr_total - w0), 32'd0);
    blank = 1'b1;
    repeat (4) tick();
    check("t3 we", 32'(bram.we_out), 32'd1);
    check("t3 addr_w", 32'(bram.addr_w_out), 32'h0FFC);
    check("t3 data_w", 32'(bram.data_w_out), 32'h12B4);
    tick();
    check("t3 mem", 32'(mem[12'hFFC]), 32'h12B4);

    // 4: blank drops in RD_W1 with a new toggle in the abort cycle
    mem[12'h641] = 16'hFFFF;
    mem[12'h642] = 16'h0000;
    cx = 8'd31; cy = 8'd100; toggle = 1'b1;
    tick();
    toggle = 1'b0;
    tick();
    tick();
    blank = 1'b0; cx = 8'd32; toggle = 1'b1;
    tick();
    toggle = 1'b0;
    w0 = wr_total;
    check("t4 busy", 32'(busy), 32'd1);
    repeat (5) tick();
    check("t4 no write", 32'(wr_total - w0), 32'd0);
    check("t4 busy held", 32'(busy), 32'd1);
    blank = 1'b1;
    repeat (4) tick();
    check("t4 we", 32'(bram.we_out), 32'd1);
    check("t4 addr_w", 32'(bram.addr_w_out), 32'h0642);
    check("t4 data_w", 32'(bram.data_w_out), 32'h8000);
    tick();
    check("t4 mem old", 32'(mem[12'h641]), 32'hFFFF);
    check("t4 mem new", 32'(mem[12'h642]), 32'h8000);
    check("t4 one write", 32'(wr_total - w0), 32'd1);

    // 5: clear with blank 1000 on / 500 off
    exp_addr = 0; order_err = 0; blank_err = 0; data_err = 0; done_at = -1;
    for (int i = 0; i < 20000; i++) begin
      blank = (i % 1500) < 1000;
      clear = (i == 0);
      #1;
      if (bram.we_out) begin
        if (!blank) blank_err++;
        if (bram.addr_w_out != 12'(exp_addr)) order_err++;
        if (bram.data_w_out != '0) data_err++;
        exp_addr++;
      end
      if (i > 2 && !busy) begin
        done_at = i;
        break;
      end
      tick();
    end
    clear = 1'b0;
    check("t5 finished", 32'(done_at >= 0), 32'd1);
    check("t5 write count", 32'(exp_addr), 32'd4096);
    check("t5 order", 32'(order_err), 32'd0);
    check("t5 blank", 32'(blank_err), 32'd0);
    check("t5 data", 32'(data_err), 32'd0);
    check("t5 mem 641", 32'(mem[12'h641]), 32'd0);
    check("t5 mem FFC", 32'(mem[12'hFFC]), 32'd0);

    // 6: simultaneous toggle+clear, then async reset mid-clear
    blank = 1'b1;
    tick();
    nz0 = wr_nonzero;
    cx = 8'd17; cy = 8'd3; toggle = 1'b1; clear = 1'b1;
    tick();
    toggle = 1'b0; clear = 1'b0;
    repeat (100) tick();
    check("t6 busy", 32'(busy), 32'd1);
    check("t6 clearing", 32'(bram.we_out), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6 rst we", 32'(bram.we_out), 32'd0);
    check("t6 rst addr_w", 32'(bram.addr_w_out), 32'd0);
    check("t6 rst data_w", 32'(bram.data_w_out), 32'd0);
    check("t6 rst addr_r", 32'(bram.addr_r_out), 32'd0);
    check("t6 rst busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    w0 = wr_total;
    repeat (50) tick();
    check("t6 no writes", 32'(wr_total - w0), 32'd0);
    check("t6 toggle dropped", 32'(wr_nonzero - nz0), 32'd0);
    check("t6 mem 031", 32'(mem[12'h031]), 32'd0);
    check("t6 busy end", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_editor.md
Name: board_editor

Overview:
Write-side counterpart to the frame renderer. It applies user edits to the board memory: toggling the cell under the cursor, or clearing the whole board.
It owns port B of the dual-port board BRAM, for both read and write. The renderer only reads port A.
All writes happen while the renderer reports blanking, so a frame never shows a half-applied edit.

Parameters:
BOARD_SIZE, 256, board edge length in cells (square board)
LOG_BOARD_SIZE, 8, log2(BOARD_SIZE)
WORD_SIZE, 16, cells per memory word
LOG_WORD_SIZE, 4, log2(WORD_SIZE)
LOG_MAX_ADDR, 12, address width; words = BOARD_SIZE*BOARD_SIZE/WORD_SIZE = 4096

Ports:
clk_130mhz  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
blank_in  in  1  renderer blank/done flag; writes permitted only while high
toggle_in  in  1  one-cycle request: invert the cell at the cursor
clear_in  in  1  one-cycle request: zero the entire board
cursor_x_in  in  LOG_BOARD_SIZE  cursor column, board coordinates
cursor_y_in  in  LOG_BOARD_SIZE  cursor row, board coordinates
data_r_in  in  WORD_SIZE  port B read data, valid 2 cycles after addr_r_out
addr_r_out  out  LOG_MAX_ADDR  port B read address
addr_w_out  out  LOG_MAX_ADDR  port B write address
data_w_out  out  WORD_SIZE  port B write data
we_out  out  1  port B write enable, one cycle per word
busy_out  out  1  high whenever a request is pending or in progress

Behaviour:
- Reset (async, any state): all outputs 0, FSM to IDLE, pending flags cleared, clear counter 0.
- Addressing:
  - Word address = y*(BOARD_SIZE/WORD_SIZE) + (x >> LOG_WORD_SIZE), truncated to LOG_MAX_ADDR bits.
  - Bit index = WORD_SIZE-1-x[LOG_WORD_SIZE-1:0], i.e. MSB = leftmost cell.
- Request capture (every cycle, any state):
  - toggle_in sets toggle_pend and latches cursor x/y into tx/ty.
  - clear_in sets clear_pend.
  - Repeated toggles while pending coalesce; the latest cursor wins.
  - toggle_in and clear_in in the same cycle: clear_pend set, toggle discarded.
  - clear_pend set: any toggle_pend is cleared.
- busy_out = toggle_pend | clear_pend | (state != IDLE), registered.
- FSM states:
  - IDLE:
    - blank_in & clear_pend -> CLEAR, counter = 0.
    - else blank_in & toggle_pend -> RD_ADDR.
    - else stay.
  - RD_ADDR: addr_r_out <= word address of (tx,ty); -> RD_W1.
  - RD_W1: -> RD_W2.
  - RD_W2: capture data_r_in; -> WRITE.
  - WRITE:
    - Drive we_out=1, addr_w_out = same address, data_w_out = captured word XOR one-hot bit; clear toggle_pend; -> IDLE.
    - we_out is high exactly one cycle.
  - CLEAR:
    - While blank_in: we_out=1, addr_w_out=counter, data_w_out=0, counter+1.
    - blank_in low: we_out=0 and counter holds (pause, resume next blank).
    - Writing address MAX_ADDR-1: clear clear_pend, -> IDLE.
- Abort rule: blank_in low in RD_ADDR/RD_W1/RD_W2 -> IDLE with toggle_pend kept; the toggle retries from scratch next blank.
- A toggle arriving in the abort cycle updates tx/ty before the retry.
- Minimum toggle latency: first blank cycle with pending request -> we_out 4 cycles later.
- Counter width LOG_MAX_ADDR+1 so the terminal compare cannot wrap.
- Only one outstanding write per cycle; we_out never high outside blank_in except for none.

Decomposition:
- Shared package (common.svh):
  - BOARD_SIZE, LOG_BOARD_SIZE, WORD_SIZE, LOG_WORD_SIZE, LOG_MAX_ADDR, WORDS_PER_ROW.
  - pos_t.
  - New enum editor_state_t {IDLE, RD_ADDR, RD_W1, RD_W2, WRITE, CLEAR}.
- One sub-module: cell_addr_calc (combinational x,y -> word address + one-hot bit mask).
  - It corrects the operator precedence of address = y*WORDS_PER_ROW + (x>>LOG_WORD_SIZE).
  - The renderer's fetch stage is to reuse it.

Test Plan:
1. Toggle at cursor (17,3), memory word 0x0000, blank_in=1:
   - addr_r_out=0x031; 4 cycles after acceptance we_out=1, addr_w_out=0x031, data_w_out=0x4000.
2. Same toggle again, word reads 0x4000 -> data_w_out=0x0000 (inverts back).
3. Toggle during active video (blank_in=0):
   - busy_out=1, no we_out.
   - blank_in rises -> write occurs 4 cycles later with latched cursor.
4. blank_in falls in RD_W1:
   - return to IDLE, no write, busy_out stays 1.
   - Next blank retries and writes correct word.
5. clear_in with blank_in toggling 1000 cycles on / 500 off:
   - exactly 4096 writes of 0, addresses 0..4095 in order, none while blank_in=0, then busy_out=0.
6. toggle_in and clear_in same cycle, plus async rst_in pulse mid-CLEAR:
   - toggle never written.
   - After reset all outputs 0 and busy_out=0 immediately.
